// File: rtl/run_length_encoder_if.sv
// Sample stream in, (value, count) run records out, for the run-length encoder.
// The encoder takes the slave view; whatever feeds it and watches its records takes the master view.
interface run_length_encoder_if #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] d_in;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_value;
    logic [CNT_W-1:0]  out_count;
    logic              busy;

    modport master (
        output in_valid, d_in, flush,
        input  out_valid, out_value, out_count, busy
    );

    modport slave (
        input  in_valid, d_in, flush,
        output out_valid, out_value, out_count, busy
    );
endinterface

// File: rtl/run_length_encoder.sv
// Compresses a qualified sample stream into (value, count) run records.
// A record is emitted on a value change, on counter saturation, or on flush.
module run_length_encoder #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    run_length_encoder_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [CNT_W-1:0]  count;
    } rec_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] run_val, run_val_nxt;
    logic [CNT_W-1:0]  run_cnt, run_cnt_nxt;
    logic              emit;
    rec_t              rec_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            run_val       <= '0;
            run_cnt       <= '0;
            bus.out_valid <= 1'b0;
            rec_q         <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            run_val       <= run_val_nxt;
            run_cnt       <= run_cnt_nxt;
            bus.out_valid <= emit;
            bus.busy      <= (state_nxt == RUN);
            // The emitted record is always the run that was open before this edge.
            if (emit) rec_q <= '{value: run_val, count: run_cnt};
        end
    end

    always_comb begin
        state_nxt   = state;
        run_val_nxt = run_val;
        run_cnt_nxt = run_cnt;
        emit        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    run_val_nxt = bus.d_in;
                    run_cnt_nxt = CNT_ONE;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    emit = 1'b1;
                    if (bus.in_valid) begin
                        run_val_nxt = bus.d_in;
                        run_cnt_nxt = CNT_ONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bus.in_valid) begin
                    if (bus.d_in != run_val || run_cnt == CNT_MAX) begin
                        // Close the run and restart at 1, so the count never wraps to 0.
                        emit        = 1'b1;
                        run_val_nxt = bus.d_in;
                        run_cnt_nxt = CNT_ONE;
                    end else begin
                        run_cnt_nxt = run_cnt + CNT_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_value = rec_q.value;
    assign bus.out_count = rec_q.count;
endmodule

// File: tb/tb_run_length_encoder.sv
// Directed and randomized bench for run_length_encoder.
// The reference model keeps the open run as a queue of the raw samples.
module tb_run_length_encoder;
    localparam int DATA_W  = 3;
    localparam int CNT_W   = 4;
    localparam int MAX_RUN = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    run_length_encoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    run_length_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] cur_q[$];
    logic              exp_valid = 1'b0;
    logic [31:0]       exp_val   = 0;
    logic [31:0]       exp_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record = first sample value of the open run, count = how many samples it holds.
    task automatic emit_run();
        exp_valid = 1'b1;
        exp_val   = 32'(cur_q[0]);
        exp_cnt   = 32'(cur_q.size());
        cur_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [DATA_W-1:0] d, input logic f);
        exp_valid = 1'b0;
        if (cur_q.size() != 0) begin
            if (f) emit_run();
            else if (v && (d != cur_q[0] || cur_q.size() == MAX_RUN)) emit_run();
        end
        if (v) cur_q.push_back(d);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [DATA_W-1:0] d, input logic f);
        reset        = r;
        bus.in_valid = v;
        bus.d_in     = d;
        bus.flush    = f;
        @(posedge clk);
        if (r) begin
            cur_q.delete();
            exp_valid = 1'b0;
            exp_val   = 0;
            exp_cnt   = 0;
        end else begin
            model_step(v, d, f);
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("out_value", 32'(bus.out_value), exp_val);
        chk("out_count", 32'(bus.out_count), exp_cnt);
        chk("busy", 32'(bus.busy), 32'(cur_q.size() != 0));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.d_in     = '0;
        bus.flush    = 1'b0;

        // 1: reset, then flushes while idle emit nothing
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_value", 32'(bus.out_value), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("idle_flush_valid", 32'(bus.out_valid), 0);

        // 2: 2,2,2,5 -> (2,3); flush -> (5,1)
        cyc(0, 1, 2, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 5, 0);
        chk("t2_value", 32'(bus.out_value), 2);
        chk("t2_count", 32'(bus.out_count), 3);
        cyc(0, 0, 0, 1);
        chk("t2_flush_count", 32'(bus.out_count), 1);
        chk("t2_busy", 32'(bus.busy), 0);

        // 3: gaps do not break a run
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 3, 0);
        chk("t3_count", 32'(bus.out_count), 2);
        cyc(0, 0, 0, 1);

        // 4: saturation at 15, then flush of the remainder
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 7, 0);
            if (i == 15) chk("t4_sat_count", 32'(bus.out_count), 15);
        end
        cyc(0, 0, 0, 1);
        chk("t4_tail_count", 32'(bus.out_count), 2);

        // 5: flush with a sample in the same cycle
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 4, 1);
        chk("t5_count", 32'(bus.out_count), 3);
        chk("t5_busy", 32'(bus.busy), 1);
        cyc(0, 0, 0, 1);
        chk("t5_value", 32'(bus.out_value), 4);

        // 6: reset discards an open run
        for (int i = 0; i < 5; i++) cyc(0, 1, 3, 0);
        cyc(1, 1, 3, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 0, 0, 1);
        chk("t6_count", 32'(bus.out_count), 1);

        // Randomized traffic, biased toward long runs of one value
        for (int i = 0; i < 800; i++) begin
            logic             r, v, f;
            logic [DATA_W-1:0] d;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 24) == 0);
            d = ($urandom_range(0, 7) < 6) ? DATA_W'(6) : DATA_W'($urandom_range(0, 7));
            cyc(r, v, d, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
